mac_job_sched: RTL

Round-robin job scheduler that shares one `part3_mac` instance among `NREQ` requesters. A job is a stream of signed (a, b) operand pairs ending with a `last` flag. The scheduler clears the MAC, streams the granted requester's pairs into it, waits for the pipeline to drain, and returns the 28-bit accumulated result tagged with the requester index. It sits between the requester ports and the MAC's `a`/`b`/`valid_in`/`f`/`valid_out` pins.

---
 rtl/mac_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/mac_job_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC job scheduler.
//   sched_state_t : scheduler FSM states
//   A_W_DEF/F_W_DEF : default operand / result widths
//   F_MAX/F_MIN : saturation limits of a default-width result
package mac_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } sched_state_t;

    localparam int unsigned A_W_DEF = 14;
    localparam int unsigned F_W_DEF = 28;

    localparam logic [F_W_DEF-1:0] F_MAX = {1'b0, {(F_W_DEF-1){1'b1}}};
    localparam logic [F_W_DEF-1:0] F_MIN = {1'b1, {(F_W_DEF-1){1'b0}}};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request at or after ptr, circularly.
//   req   : request bits
//   ptr   : search start index
//   grant : one-hot grant (zero if no request)
//   idx   : index of the granted request (0 if none)
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  idx
);

    localparam int unsigned IW = $clog2(NREQ);

    // Walk offsets 0..NREQ-1 from ptr; the first hit wins.
    always_comb begin
        int unsigned c;
        logic        found;
        c     = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c = 32'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!found && req[IW'(c)]) begin
                found          = 1'b1;
                grant[IW'(c)]  = 1'b1;
                idx            = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mac_job_sched.sv
// Round-robin job scheduler sharing one MAC among NREQ requesters.
// Clears the MAC, streams one requester's operand pairs, drains the MAC
// pipeline and presents the accumulated result tagged with the requester id.
//   clk, reset (sync, active-low)
//   req_valid/req_ready/req_a/req_b/req_last : per-requester element streams
//   mac_a/mac_b/mac_valid_in/mac_clear       : to the MAC
//   mac_f/mac_valid_out                      : from the MAC
//   res_valid/res_ready/res_f/res_id         : job result handshake
//   res_sat : result-is-saturated flag, only with MAC_JOB_SCHED_SAT_FLAG_EN
module mac_job_sched
    import mac_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned A_W     = A_W_DEF,
    parameter int unsigned F_W     = F_W_DEF,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*A_W-1:0]      req_a,
    input  logic [NREQ*A_W-1:0]      req_b,
    input  logic [NREQ-1:0]          req_last,
    output logic [A_W-1:0]           mac_a,
    output logic [A_W-1:0]           mac_b,
    output logic                     mac_valid_in,
    output logic                     mac_clear,
    input  logic [F_W-1:0]           mac_f,
    input  logic                     mac_valid_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [F_W-1:0]           res_f,
    output logic [$clog2(NREQ)-1:0]  res_id
`ifdef MAC_JOB_SCHED_SAT_FLAG_EN
    ,
    output logic                     res_sat
`endif
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAC_LAT + 2);

    sched_state_t   state_q, state_d;
    logic [IW-1:0]  grant_q, rr_ptr_q, arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic           arb_any;
    logic [CW-1:0]  outst_q;
    logic [A_W-1:0] mac_a_q, mac_b_q, sel_a, sel_b;
    logic [F_W-1:0] res_f_q;
    logic [IW-1:0]  res_id_q;
    logic           accept, dec, capture;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_any = |arb_grant;

    assign sel_a   = req_a[grant_q*A_W +: A_W];
    assign sel_b   = req_b[grant_q*A_W +: A_W];
    assign accept  = (state_q == STREAM) && req_valid[grant_q];
    // Late MAC outputs with nothing outstanding (e.g. after reset) are ignored.
    assign dec     = mac_valid_out && (outst_q != '0);
    assign capture = (state_q == DRAIN) && dec && (outst_q == CW'(1));

    // Element path is combinational so each accept reaches the MAC the same cycle;
    // on gaps the operand bus holds the last forwarded pair.
    assign mac_valid_in = accept;
    assign mac_a        = accept ? sel_a : mac_a_q;
    assign mac_b        = accept ? sel_b : mac_b_q;
    assign mac_clear    = (state_q == CLEAR);
    assign res_valid    = (state_q == RESULT);
    assign res_f        = res_f_q;
    assign res_id       = res_id_q;

    // Only the granted requester is readied, and only while streaming.
    always_comb begin
        req_ready = '0;
        if (state_q == STREAM) req_ready[grant_q] = 1'b1;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = CLEAR;
            CLEAR:   state_d = STREAM;
            STREAM:  if (accept && req_last[grant_q]) state_d = DRAIN;
            DRAIN:   if (capture) state_d = RESULT;
            RESULT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant, pointer, outstanding counter and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            outst_q  <= '0;
            mac_a_q  <= '0;
            mac_b_q  <= '0;
            res_f_q  <= '0;
            res_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && arb_any) grant_q <= arb_idx;
            if (accept) begin
                mac_a_q <= sel_a;
                mac_b_q <= sel_b;
            end
            case ({accept, dec})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   outst_q <= outst_q - CW'(1);
                default: outst_q <= outst_q;
            endcase
            if (capture) begin
                res_f_q  <= mac_f;
                res_id_q <= grant_q;
            end
            if (state_q == RESULT && res_ready)
                rr_ptr_q <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        end
    end

`ifdef MAC_JOB_SCHED_SAT_FLAG_EN
    localparam logic [F_W-1:0] SAT_HI = {1'b0, {(F_W-1){1'b1}}};
    localparam logic [F_W-1:0] SAT_LO = {1'b1, {(F_W-1){1'b0}}};
    logic res_sat_q;

    // Flag results pinned at either saturation limit.
    always_ff @(posedge clk) begin
        if (!reset)       res_sat_q <= 1'b0;
        else if (capture) res_sat_q <= (mac_f == SAT_HI) || (mac_f == SAT_LO);
    end

    assign res_sat = res_sat_q;
`endif

endmodule
